// File: rtl/tile_scroll_addr_gen_pkg.sv
// Shared tile-map geometry defaults for the background address generator,
// tile ROM and sprite blocks.
package tile_scroll_addr_gen_pkg;

  localparam int DEF_SIZE_X     = 10;
  localparam int DEF_SIZE_Y     = 10;
  localparam int DEF_SIZE_ADDR  = 13;
  localparam int DEF_TILE_LOG2  = 3;
  localparam int DEF_MAP_COLS   = 80;
  localparam int DEF_MAP_ROWS   = 60;
  localparam int DEF_BASE_ADDR  = 0;
  localparam int DEF_BLANK_ADDR = 0;

  // Map extent in pixels for a given tile count along one axis.
  function automatic int map_px(input int tiles, input int tile_log2);
    return tiles << tile_log2;
  endfunction

endpackage

// File: rtl/tile_scroll_addr_gen_if.sv
// Pixel-in / tile-address-out bundle between the pixel counter and tile memory.
interface tile_scroll_addr_gen_if #(
  parameter int SIZE_X    = 10,
  parameter int SIZE_Y    = 10,
  parameter int SIZE_ADDR = 13,
  parameter int TILE_LOG2 = 3
) ();

  logic [SIZE_X-1:0]    pixel_x;
  logic [SIZE_Y-1:0]    pixel_y;
  logic                 pixel_valid;
  logic                 frame_sync;
  logic [SIZE_X-1:0]    scroll_x;
  logic [SIZE_Y-1:0]    scroll_y;
  logic [SIZE_ADDR-1:0] addr_block;
  logic [TILE_LOG2-1:0] tile_px;
  logic [TILE_LOG2-1:0] tile_py;
  logic                 out_of_map;
  logic                 addr_valid;

  modport master (
    output pixel_x, pixel_y, pixel_valid, frame_sync, scroll_x, scroll_y,
    input  addr_block, tile_px, tile_py, out_of_map, addr_valid
  );

  modport slave (
    input  pixel_x, pixel_y, pixel_valid, frame_sync, scroll_x, scroll_y,
    output addr_block, tile_px, tile_py, out_of_map, addr_valid
  );

endinterface

// File: rtl/tile_scroll_addr_gen_scroll_shadow_reg.sv
// Per-axis scroll shadow register: captures the requested scroll once per frame,
// folded into the map range so the datapath needs only a single wrap subtract.
module tile_scroll_addr_gen_scroll_shadow_reg #(
  parameter int W = 10,
  parameter int M = 640
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         frame_sync,
  input  logic [W-1:0] scroll_in,
  output logic [W-1:0] shadow
);

  function automatic logic [W-1:0] reduce(input logic [W-1:0] v);
    int vi;
    vi = 32'(v);
    if (vi < M)          return v;
    else if (vi < 2 * M) return W'(vi - M);
    else                 return W'(M - 1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset)           shadow <= '0;
    else if (frame_sync) shadow <= reduce(scroll_in);
  end

endmodule

// File: rtl/tile_scroll_addr_gen.sv
// Scrollable background tile-map address generator: pixel + frame scroll ->
// tile address and in-tile offsets, wrap or clamp at map edges, 2-cycle latency.
module tile_scroll_addr_gen
  import tile_scroll_addr_gen_pkg::*;
#(
  parameter int SIZE_X     = DEF_SIZE_X,
  parameter int SIZE_Y     = DEF_SIZE_Y,
  parameter int SIZE_ADDR  = DEF_SIZE_ADDR,
  parameter int TILE_LOG2  = DEF_TILE_LOG2,
  parameter int MAP_COLS   = DEF_MAP_COLS,
  parameter int MAP_ROWS   = DEF_MAP_ROWS,
  parameter int BASE_ADDR  = DEF_BASE_ADDR,
  parameter int BLANK_ADDR = DEF_BLANK_ADDR,
  parameter int WRAP_EN    = 1
) (
  input logic                  clk,
  input logic                  reset,
  tile_scroll_addr_gen_if.slave bus
);

  localparam int MAP_W = map_px(MAP_COLS, TILE_LOG2);
  localparam int MAP_H = map_px(MAP_ROWS, TILE_LOG2);
  localparam logic [SIZE_X:0]      MAP_W_X = (SIZE_X + 1)'(MAP_W);
  localparam logic [SIZE_Y:0]      MAP_H_Y = (SIZE_Y + 1)'(MAP_H);
  localparam logic [SIZE_ADDR-1:0] BASE_A  = SIZE_ADDR'(BASE_ADDR);
  localparam logic [SIZE_ADDR-1:0] BLANK_A = SIZE_ADDR'(BLANK_ADDR);
  localparam logic [SIZE_ADDR-1:0] COLS_A  = SIZE_ADDR'(MAP_COLS);

  logic [SIZE_X-1:0] sx;
  logic [SIZE_Y-1:0] sy;

  tile_scroll_addr_gen_scroll_shadow_reg #(.W(SIZE_X), .M(MAP_W)) u_shadow_x (
    .clk(clk), .reset(reset), .frame_sync(bus.frame_sync),
    .scroll_in(bus.scroll_x), .shadow(sx)
  );

  tile_scroll_addr_gen_scroll_shadow_reg #(.W(SIZE_Y), .M(MAP_H)) u_shadow_y (
    .clk(clk), .reset(reset), .frame_sync(bus.frame_sync),
    .scroll_in(bus.scroll_y), .shadow(sy)
  );

  logic [SIZE_X:0] wx_sum, wx_n, wx_p1;
  logic [SIZE_Y:0] wy_sum, wy_n, wy_p1;
  logic            oob_n, oob_p1, vld_p1;

  always_comb begin
    wx_sum = {1'b0, bus.pixel_x} + {1'b0, sx};
    wy_sum = {1'b0, bus.pixel_y} + {1'b0, sy};
    wx_n   = wx_sum;
    wy_n   = wy_sum;
    oob_n  = 1'b0;
    if (WRAP_EN != 0) begin
      if (wx_sum >= MAP_W_X) wx_n = wx_sum - MAP_W_X;
      if (wy_sum >= MAP_H_Y) wy_n = wy_sum - MAP_H_Y;
    end else begin
      oob_n = (wx_sum >= MAP_W_X) || (wy_sum >= MAP_H_Y);
    end
  end

  // Stage 1: scrolled world coordinates
  always_ff @(posedge clk) begin
    wx_p1  <= wx_n;
    wy_p1  <= wy_n;
    oob_p1 <= oob_n;
  end

  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= bus.pixel_valid;
  end

  logic [SIZE_ADDR-1:0] col_a, row_a, addr_n;

  always_comb begin
    col_a  = SIZE_ADDR'(wx_p1 >> TILE_LOG2);
    row_a  = SIZE_ADDR'(wy_p1 >> TILE_LOG2);
    addr_n = BASE_A + row_a * COLS_A + col_a;
  end

  logic [SIZE_ADDR-1:0] addr_p2;
  logic [TILE_LOG2-1:0] px_p2, py_p2;
  logic                 oom_p2, vld_p2;

  // Stage 2: tile address; data holds across invalid cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_p2 <= '0;
      px_p2   <= '0;
      py_p2   <= '0;
      oom_p2  <= 1'b0;
      vld_p2  <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      oom_p2 <= vld_p1 & oob_p1;
      if (vld_p1) begin
        if (oob_p1) begin
          addr_p2 <= BLANK_A;
          px_p2   <= '0;
          py_p2   <= '0;
        end else begin
          addr_p2 <= addr_n;
          px_p2   <= wx_p1[TILE_LOG2-1:0];
          py_p2   <= wy_p1[TILE_LOG2-1:0];
        end
      end
    end
  end

  assign bus.addr_block = addr_p2;
  assign bus.tile_px    = px_p2;
  assign bus.tile_py    = py_p2;
  assign bus.out_of_map = oom_p2;
  assign bus.addr_valid = vld_p2;

endmodule

// File: tb/tb_tile_scroll_addr_gen.sv
// Directed and randomised checks of the tile address generator, one wrapping
// and one clamping instance driven with identical stimulus.
module tb_tile_scroll_addr_gen;

  localparam int CLAMP_BLANK = 5000;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  tile_scroll_addr_gen_if bw ();
  tile_scroll_addr_gen_if bc ();

  tile_scroll_addr_gen u_wrap (
    .clk(clk), .reset(reset), .bus(bw.slave)
  );

  tile_scroll_addr_gen #(.WRAP_EN(0), .BLANK_ADDR(CLAMP_BLANK)) u_clamp (
    .clk(clk), .reset(reset), .bus(bc.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input int x, input int y, input logic v, input logic fs);
    bw.pixel_x = 10'(x); bw.pixel_y = 10'(y); bw.pixel_valid = v; bw.frame_sync = fs;
    bc.pixel_x = 10'(x); bc.pixel_y = 10'(y); bc.pixel_valid = v; bc.frame_sync = fs;
  endtask

  task automatic set_scroll(input int sx, input int sy);
    bw.scroll_x = 10'(sx); bw.scroll_y = 10'(sy);
    bc.scroll_x = 10'(sx); bc.scroll_y = 10'(sy);
  endtask

  // Present one pixel, then idle; returns on the cycle its result is visible.
  task automatic pixel(input int x, input int y);
    tick(); drive(x, y, 1'b1, 1'b0);
    tick(); drive(0, 0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic frame(input int sx, input int sy);
    tick(); set_scroll(sx, sy); drive(0, 0, 1'b0, 1'b1);
    tick(); drive(0, 0, 1'b0, 1'b0);
  endtask

  task automatic chk_w(input string tag, input int a, input int px, input int py);
    check({tag, "_w_vld"},  bw.addr_valid, 1);
    check({tag, "_w_addr"}, bw.addr_block, a);
    check({tag, "_w_px"},   bw.tile_px, px);
    check({tag, "_w_py"},   bw.tile_py, py);
    check({tag, "_w_oom"},  bw.out_of_map, 0);
  endtask

  task automatic chk_c(input string tag, input int a, input int px, input int py, input int oom);
    check({tag, "_c_vld"},  bc.addr_valid, 1);
    check({tag, "_c_addr"}, bc.addr_block, a);
    check({tag, "_c_px"},   bc.tile_px, px);
    check({tag, "_c_py"},   bc.tile_py, py);
    check({tag, "_c_oom"},  bc.out_of_map, oom);
  endtask

  function automatic int red(input int v, input int m);
    if (v < m)     return v;
    if (v < 2 * m) return v - m;
    return m - 1;
  endfunction

  typedef struct {
    bit v;
    int aw, pxw, pyw;
    int ac, pxc, pyc, oc;
  } exp_t;

  function automatic exp_t model(input bit v, input int x, input int y, input int sx, input int sy);
    exp_t e;
    int wx, wy;
    e.v = v;
    wx = x + sx; wy = y + sy;
    if (wx >= 640 || wy >= 480) begin
      e.ac = CLAMP_BLANK; e.pxc = 0; e.pyc = 0; e.oc = 1;
    end else begin
      e.ac = (wy / 8) * 80 + wx / 8; e.pxc = wx % 8; e.pyc = wy % 8; e.oc = 0;
    end
    if (wx >= 640) wx = wx - 640;
    if (wy >= 480) wy = wy - 480;
    e.aw = (wy / 8) * 80 + wx / 8; e.pxw = wx % 8; e.pyw = wy % 8;
    return e;
  endfunction

  task automatic random_run(input int ncyc);
    exp_t d1, d2, e;
    int sx, sy, rsx, rsy, x, y;
    bit v;
    rsx = $urandom_range(0, 1023);
    rsy = $urandom_range(0, 1023);
    sx = red(rsx, 640);
    sy = red(rsy, 480);
    frame(rsx, rsy);
    tick(); tick();
    d1 = '{default: 0};
    d2 = '{default: 0};
    for (int k = 0; k < ncyc + 2; k++) begin
      tick();
      check("rnd_w_vld", bw.addr_valid, d2.v);
      check("rnd_c_vld", bc.addr_valid, d2.v);
      check("rnd_w_oom", bw.out_of_map, 0);
      check("rnd_c_oom", bc.out_of_map, d2.v ? d2.oc : 0);
      if (d2.v) begin
        check("rnd_w_addr", bw.addr_block, d2.aw);
        check("rnd_w_px",   bw.tile_px, d2.pxw);
        check("rnd_w_py",   bw.tile_py, d2.pyw);
        check("rnd_c_addr", bc.addr_block, d2.ac);
        check("rnd_c_px",   bc.tile_px, d2.pxc);
        check("rnd_c_py",   bc.tile_py, d2.pyc);
      end
      v = (k < ncyc) && ($urandom_range(0, 9) != 0);
      x = $urandom_range(0, 639);
      y = $urandom_range(0, 479);
      drive(x, y, v, 1'b0);
      e = model(v, x, y, sx, sy);
      d2 = d1;
      d1 = e;
    end
    drive(0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    set_scroll(0, 0);
    drive(0, 0, 1'b0, 1'b0);
    repeat (3) tick();
    reset = 1'b0;
    check("rst_w_vld",  bw.addr_valid, 0);
    check("rst_w_addr", bw.addr_block, 0);
    check("rst_w_oom",  bw.out_of_map, 0);
    check("rst_c_vld",  bc.addr_valid, 0);
    check("rst_c_oom",  bc.out_of_map, 0);

    // Basic mapping, no scroll
    pixel(0, 0);     chk_w("p00", 0, 0, 0);
    pixel(639, 479); chk_w("pmax", 4799, 7, 7); chk_c("pmax", 4799, 7, 7, 0);

    // Wrap in both axes
    frame(8, 16);
    pixel(632, 0);   chk_w("wrapx", 160, 0, 0);
    pixel(0, 470);   chk_w("wrapy", 1, 0, 6);

    // Clamp at the right edge
    frame(8, 0);
    pixel(631, 5);   chk_c("edge_in", 79, 7, 5, 0);
    pixel(632, 5);   chk_c("edge_out", CLAMP_BLANK, 0, 0, 1);
    chk_w("edge_out", 0, 0, 5);
    tick();
    check("hold_c_vld",  bc.addr_valid, 0);
    check("hold_c_oom",  bc.out_of_map, 0);
    check("hold_c_addr", bc.addr_block, CLAMP_BLANK);
    check("hold_w_addr", bw.addr_block, 0);
    check("hold_w_py",   bw.tile_py, 5);

    // Scroll reduction: 700 -> 60, then 1023/1023 -> 383/479
    frame(700, 0);
    pixel(0, 0);     chk_w("red700", 7, 4, 0);
    frame(1023, 1023);
    pixel(0, 0);     chk_w("red1023", 4767, 7, 7);

    // Scroll change without frame_sync is ignored
    tick(); set_scroll(0, 0);
    pixel(0, 0);     chk_w("nosync", 4767, 7, 7);

    // frame_sync with a valid pixel: that pixel still uses the old scroll
    tick(); drive(0, 0, 1'b1, 1'b1);
    tick(); drive(0, 0, 1'b0, 1'b0);
    tick();          chk_w("fs_same", 4767, 7, 7);
    pixel(0, 0);     chk_w("fs_next", 0, 0, 0);

    random_run(500);
    random_run(500);

    // Reset mid-line drops in-flight pixels and clears shadow scroll
    frame(200, 100);
    tick(); drive(639, 479, 1'b1, 1'b0);
    tick(); drive(100, 100, 1'b1, 1'b0); reset = 1'b1;
    tick();
    check("mrst_w_vld",  bw.addr_valid, 0);
    check("mrst_w_addr", bw.addr_block, 0);
    check("mrst_w_px",   bw.tile_px, 0);
    check("mrst_w_py",   bw.tile_py, 0);
    check("mrst_c_oom",  bc.out_of_map, 0);
    reset = 1'b0; drive(8, 16, 1'b1, 1'b0);
    tick(); drive(0, 0, 1'b0, 1'b0);
    check("mrst_drop_vld", bw.addr_valid, 0);
    tick();          chk_w("mrst_shadow0", 161, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
